// File: rtl/pipe_stall_ctrl.sv
// Valid/stall sequencer for a pipelined fixed-point datapath.
// One valid bit per registered stage, per-stage load enables, ready/valid on both ends,
// bubble collapsing, synchronous flush and a RUN/DRAIN intake gate.
module pipe_stall_ctrl #(
  parameter int unsigned level_num    = 8,
  parameter int unsigned reg_interval = 2,
  localparam int unsigned stage_num = (reg_interval == 0) ? 0 : ((level_num - 1) / reg_interval + 1),
  localparam int unsigned cnt_w     = (stage_num == 0) ? 1 : $clog2(stage_num + 1),
  localparam int unsigned en_w      = (stage_num == 0) ? 1 : stage_num
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [en_w-1:0]  stage_en,
  output logic [cnt_w-1:0] occupancy
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  logic             intake_ok;
  logic [cnt_w-1:0] occ_q;
  logic [cnt_w-1:0] occ_nxt;

  assign intake_ok = (state == RUN);
  assign occupancy = occ_q;

  if (stage_num == 0) begin : g_wire
    // No registered stages: the handshake passes straight through.
    logic unused_in;
    assign unused_in = flush ^ intake_ok;
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign stage_en  = '0;
    assign occ_nxt   = '0;
  end else begin : g_pipe
    logic [stage_num-1:0] v_q;
    logic [stage_num-1:0] v_nxt;
    logic [stage_num-1:0] src;
    logic [stage_num-1:0] rdy;
    logic [stage_num-1:0] en;
    logic                 in_hs;
    logic                 out_hs;

    // Per-stage source, readiness chain (output end backward), load enables and next valids.
    always_comb begin : p_stage
      logic r;
      src   = '0;
      rdy   = '0;
      en    = '0;
      v_nxt = v_q;
      r     = out_ready;
      src[0] = in_valid & intake_ok;
      for (int k = 1; k < int'(stage_num); k++) begin
        src[k] = v_q[k-1];
      end
      for (int k = int'(stage_num) - 1; k >= 0; k--) begin
        r      = ~v_q[k] | r;
        rdy[k] = r;
      end
      for (int k = 0; k < int'(stage_num); k++) begin
        en[k] = rdy[k] & src[k];
        if (rdy[k]) begin
          v_nxt[k] = src[k];
        end
      end
      if (flush) begin
        v_nxt = '0;
        en    = '0;
      end
    end

    assign in_ready  = rdy[0] & intake_ok & ~flush;
    assign out_valid = v_q[stage_num-1];
    assign stage_en  = en;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready & ~flush;
    assign occ_nxt   = flush ? '0 : cnt_w'(occ_q + cnt_w'(in_hs) - cnt_w'(out_hs));

    // Stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
      end else begin
        v_q <= v_nxt;
      end
    end
  end

  // Occupancy counter and RUN/DRAIN sequencing with a one-cycle completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
      occ_q      <= '0;
    end else begin
      occ_q      <= occ_nxt;
      drain_done <= 1'b0;
      case (state)
        RUN: begin
          if (drain_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ_nxt == '0) begin
            state      <= RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: token-slot reference model plus directed timing checks.
module tb_pipe_stall_ctrl;
  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, flush, drain_req;
  logic       in_ready, out_valid, drain_done;
  logic [3:0] stage_en;
  logic [2:0] occupancy;
  logic       z_in_ready, z_out_valid, z_drain_done;
  logic [0:0] z_stage_en;
  logic [0:0] z_occupancy;

  pipe_stall_ctrl #(.level_num(8), .reg_interval(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .drain_req(drain_req), .drain_done(drain_done), .stage_en(stage_en),
    .occupancy(occupancy)
  );

  pipe_stall_ctrl #(.level_num(8), .reg_interval(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .out_valid(z_out_valid), .out_ready(out_ready), .flush(flush),
    .drain_req(drain_req), .drain_done(z_drain_done), .stage_en(z_stage_en),
    .occupancy(z_occupancy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: presence of a token in each stage slot, plus intake mode.
  bit [S-1:0] tok;
  bit         m_drain, m_done;
  bit         d_iv, d_or, d_fl, d_dr;
  logic [9:0] exp_v, obs_v;

  // A slot can take a new token when the sink is ready or some slot at/after it is empty.
  function automatic bit acc_ok(int k);
    if (d_or) return 1'b1;
    for (int j = k; j < int'(S); j++) if (!tok[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit src_of(int k);
    if (k == 0) return d_iv && !m_drain;
    return tok[k-1];
  endfunction

  function automatic int ntok();
    int n = 0;
    for (int j = 0; j < int'(S); j++) n += int'(tok[j]);
    return n;
  endfunction

  task automatic model_reset();
    tok = '0; m_drain = 1'b0; m_done = 1'b0;
  endtask

  // Drive one cycle of inputs, form the model's expectation and sample the DUT.
  task automatic setup(input bit iv, input bit orr, input bit fl, input bit dr);
    bit [3:0] e_en;
    bit       e_ir;
    in_valid = iv; out_ready = orr; flush = fl; drain_req = dr;
    d_iv = iv; d_or = orr; d_fl = fl; d_dr = dr;
    e_ir = !fl && !m_drain && acc_ok(0);
    for (int k = 0; k < int'(S); k++) e_en[k] = !fl && src_of(k) && acc_ok(k);
    exp_v = {e_ir, tok[S-1], e_en, 3'(ntok()), m_done};
    #1;
    obs_v = {in_ready, out_valid, stage_en, occupancy, drain_done};
  endtask

  // Clock edge: advance the model with the inputs of the cycle just sampled.
  task automatic advance();
    bit [S-1:0] nt;
    @(posedge clk);
    nt = '0;
    if (!d_fl) for (int k = 0; k < int'(S); k++) nt[k] = acc_ok(k) ? src_of(k) : tok[k];
    tok = nt;
    m_done = 1'b0;
    if (!m_drain) begin
      if (d_dr) m_drain = 1'b1;
    end else if (ntok() == 0) begin
      m_drain = 1'b0;
      m_done  = 1'b1;
    end
    @(negedge clk);
  endtask

  // Two flush cycles leave the pipe empty and in RUN from any state.
  task automatic settle();
    repeat (2) begin setup(1'b0, 1'b0, 1'b1, 1'b0); advance(); end
  endtask

  task automatic test_reset();
    model_reset();
    setup(1'b1, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (obs_v !== exp_v) begin nerr++; $display("FAIL reset_state: got %b want %b", obs_v, exp_v); end
    nvec++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || drain_done !== 1'b0) begin
      nerr++; $display("FAIL reset_outputs: got occ=%0d ov=%b dd=%b want 0 0 0", occupancy, out_valid, drain_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    bit ev;
    settle();
    for (int i = 0; i < 16; i++) begin
      setup(i < 10, 1'b1, 1'b0, 1'b0);
      nvec++;
      if (obs_v !== exp_v) begin nerr++; $display("FAIL stream_model step %0d: got %b want %b", i, obs_v, exp_v); end
      ev = (i >= 4) && (i <= 13);
      nvec++;
      if (out_valid !== ev) begin nerr++; $display("FAIL stream_latency step %0d: got %b want %b", i, out_valid, ev); end
      if (i >= 4 && i <= 10) begin
        nvec++;
        if (occupancy !== 3'd4) begin nerr++; $display("FAIL stream_occ step %0d: got %0d want 4", i, occupancy); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    bit er;
    settle();
    for (int i = 0; i < 8; i++) begin
      setup(i % 2 == 0, 1'b0, 1'b0, 1'b0);
      nvec++;
      if (obs_v !== exp_v) begin nerr++; $display("FAIL stall_model step %0d: got %b want %b", i, obs_v, exp_v); end
      er = (i < 7);
      nvec++;
      if (in_ready !== er) begin nerr++; $display("FAIL stall_in_ready step %0d: got %b want %b", i, in_ready, er); end
      advance();
    end
    nvec++;
    if (occupancy !== 3'd4) begin nerr++; $display("FAIL stall_full: got %0d want 4", occupancy); end
    for (int j = 0; j < 6; j++) begin
      setup(1'b0, 1'b1, 1'b0, 1'b0);
      nvec++;
      if (obs_v !== exp_v) begin nerr++; $display("FAIL stall_release_model step %0d: got %b want %b", j, obs_v, exp_v); end
      nvec++;
      if (out_valid !== (j < 4)) begin nerr++; $display("FAIL stall_release step %0d: got %b want %b", j, out_valid, j < 4); end
      advance();
    end
  endtask

  task automatic test_full_both();
    settle();
    repeat (4) begin setup(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    setup(1'b1, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (obs_v !== exp_v) begin nerr++; $display("FAIL full_both_model: got %b want %b", obs_v, exp_v); end
    nvec++;
    if ({in_ready, stage_en, occupancy} !== {1'b1, 4'b1111, 3'd4}) begin
      nerr++; $display("FAIL full_both: got ir=%b en=%b occ=%0d want 1 1111 4", in_ready, stage_en, occupancy);
    end
    advance();
    setup(1'b0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (occupancy !== 3'd4) begin nerr++; $display("FAIL full_both_occ: got %0d want 4", occupancy); end
    advance();
  endtask

  task automatic test_flush();
    settle();
    repeat (3) begin setup(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    setup(1'b1, 1'b0, 1'b1, 1'b0);
    nvec++;
    if ({in_ready, stage_en, occupancy} !== {1'b0, 4'b0000, 3'd3}) begin
      nerr++; $display("FAIL flush_cycle: got ir=%b en=%b occ=%0d want 0 0000 3", in_ready, stage_en, occupancy);
    end
    advance();
    setup(1'b0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if ({out_valid, occupancy} !== {1'b0, 3'd0}) begin
      nerr++; $display("FAIL flush_after: got ov=%b occ=%0d want 0 0", out_valid, occupancy);
    end
    nvec++;
    if (obs_v !== exp_v) begin nerr++; $display("FAIL flush_model: got %b want %b", obs_v, exp_v); end
    advance();
  endtask

  task automatic test_drain();
    settle();
    repeat (2) begin setup(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    repeat (3) begin setup(1'b0, 1'b0, 1'b0, 1'b0); advance(); end
    setup(1'b0, 1'b1, 1'b0, 1'b1); advance();
    setup(1'b1, 1'b1, 1'b0, 1'b0);
    nvec++;
    if ({in_ready, drain_done} !== 2'b00) begin nerr++; $display("FAIL drain_block: got ir=%b dd=%b want 0 0", in_ready, drain_done); end
    advance();
    setup(1'b1, 1'b1, 1'b0, 1'b0);
    nvec++;
    if ({in_ready, drain_done} !== 2'b11) begin nerr++; $display("FAIL drain_done: got ir=%b dd=%b want 1 1", in_ready, drain_done); end
    nvec++;
    if (obs_v !== exp_v) begin nerr++; $display("FAIL drain_model: got %b want %b", obs_v, exp_v); end
    advance();
    setup(1'b0, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (drain_done !== 1'b0) begin nerr++; $display("FAIL drain_pulse: got %b want 0", drain_done); end
    advance();
    // Drain request on an already empty pipe.
    settle();
    setup(1'b0, 1'b1, 1'b0, 1'b1); advance();
    setup(1'b1, 1'b1, 1'b0, 1'b0);
    nvec++;
    if ({in_ready, drain_done} !== 2'b00) begin nerr++; $display("FAIL drain_empty_entry: got ir=%b dd=%b want 0 0", in_ready, drain_done); end
    advance();
    setup(1'b0, 1'b1, 1'b0, 1'b0);
    nvec++;
    if ({in_ready, drain_done} !== 2'b11) begin nerr++; $display("FAIL drain_empty_done: got ir=%b dd=%b want 1 1", in_ready, drain_done); end
    advance();
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 400; i++) begin
      setup($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 23) == 0);
      nvec++;
      if (obs_v !== exp_v) begin nerr++; $display("FAIL random step %0d: got %b want %b", i, obs_v, exp_v); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    settle();
    repeat (3) begin setup(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    setup(1'b0, 1'b0, 1'b0, 1'b1); advance();
    setup(1'b1, 1'b0, 1'b0, 1'b0);
    nvec++;
    if ({in_ready, out_valid, occupancy} !== {1'b0, 1'b1, 3'd3}) begin
      nerr++; $display("FAIL reset_mid_pre: got ir=%b ov=%b occ=%0d want 0 1 3", in_ready, out_valid, occupancy);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({in_ready, out_valid, occupancy, drain_done} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_mid: got ir=%b ov=%b occ=%0d dd=%b want 1 0 0 0", in_ready, out_valid, occupancy, drain_done);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_zero_stage();
    bit iv, orr;
    settle();
    for (int i = 0; i < 8; i++) begin
      iv = 1'($urandom_range(0, 1)); orr = 1'(i % 2);
      setup(iv, orr, 1'b0, 1'b0);
      nvec++;
      if ({z_in_ready, z_out_valid, z_stage_en, z_occupancy} !== {orr, iv, 1'b0, 1'b0}) begin
        nerr++; $display("FAIL zero_stage step %0d: got ir=%b ov=%b en=%b occ=%b want %b %b 0 0",
                         i, z_in_ready, z_out_valid, z_stage_en, z_occupancy, orr, iv);
      end
      out_ready = ~orr;
      #1;
      nvec++;
      if (z_in_ready !== ~orr) begin nerr++; $display("FAIL zero_stage_comb step %0d: got %b want %b", i, z_in_ready, ~orr); end
      out_ready = orr;
      advance();
    end
    setup(1'b0, 1'b1, 1'b0, 1'b1); advance();
    setup(1'b0, 1'b1, 1'b0, 1'b0); advance();
    setup(1'b0, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (z_drain_done !== 1'b1) begin nerr++; $display("FAIL zero_stage_drain: got %b want 1", z_drain_done); end
    advance();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; drain_req = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_full_both();
    test_flush();
    test_drain();
    test_random();
    test_reset_mid();
    test_zero_stage();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
